time_set_ctrl: RTL and testbench

User-interface controller that sequences the time-of-day counter. It turns two debounced push-button levels into the single-cycle `adj_hour_p`, `adj_min_p` and `clear_time_p` strobes the counter consumes. It provides hold-to-repeat, long-press clear and an inactivity timeout. It also drives the set-mode indication and display blink for the display driver, and runs on the same 1 kHz system clock as the counter.

---
 rtl/time_ctrl_pkg.sv | 16 +
 rtl/key_hold_rpt.sv | 85 ++++++++
 rtl/time_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_ctrl_pkg.sv
// Shared types and defaults for the time-set controller.
// State encodings and 1 kHz timing constants.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam int unsigned DEF_HOLD_CYC    = 1000;
  localparam int unsigned DEF_REPEAT_CYC  = 200;
  localparam int unsigned DEF_TIMEOUT_CYC = 10000;
  localparam int unsigned DEF_BLINK_HALF  = 500;

endpackage

// File: rtl/key_hold_rpt.sv
// Per-button edge detect, long-press and auto-repeat timing.
// Pulses are combinational from the level and local state.
module key_hold_rpt
  import time_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic repeat_en,
  input  logic arm,
  output logic rise_p,
  output logic fall_p,
  output logic long_p,
  output logic rpt_p
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);

  logic          r_prev;
  logic          r_blk;
  logic          r_act;
  logic          r_long;
  logic [HW-1:0] r_hcnt;
  logic [RW-1:0] r_rcnt;

  logic w_rise;
  logic w_fall;
  logic w_long;
  logic w_per;
  logic w_go;

  // A blocked key stays silent until the level drops.
  assign w_rise = btn & ~r_prev & ~r_blk;
  assign w_fall = ~btn & r_prev;
  assign w_long = btn & r_act & ~r_long
                & (r_hcnt == HW'(HOLD_CYC));
  assign w_per  = btn & r_act & r_long
                & (r_rcnt == RW'(REPEAT_CYC));
  assign w_go   = btn & arm;

  assign rise_p = w_rise;
  assign fall_p = w_fall;
  assign long_p = w_long;
  assign rpt_p  = repeat_en & (w_long | w_per);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b1;
      r_blk  <= 1'b0;
      r_act  <= 1'b0;
      r_long <= 1'b0;
      r_hcnt <= '0;
      r_rcnt <= '0;
    end else begin
      r_prev <= btn;
      r_blk  <= arm ? (btn & r_blk) : btn;
      if (!w_go) begin
        r_act  <= 1'b0;
        r_long <= 1'b0;
        r_hcnt <= '0;
        r_rcnt <= '0;
      end else begin
        if (w_rise) begin
          r_act  <= 1'b1;
          r_hcnt <= HW'(1);
        end else if (r_act && r_hcnt != HW'(HOLD_CYC)) begin
          r_hcnt <= r_hcnt + HW'(1);
        end
        if (w_long) begin
          r_long <= 1'b1;
          r_rcnt <= RW'(1);
        end else if (w_per) begin
          r_rcnt <= RW'(1);
        end else if (r_long && r_rcnt != RW'(REPEAT_CYC)) begin
          r_rcnt <= r_rcnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button UI for the time-of-day counter: set modes,
// adjust strobes, long-press clear, timeout and blink.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       adj_hour_p,
  output logic       adj_min_p,
  output logic       clear_time_p,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  state_t        r_state;
  logic          r_mpress;
  logic [TW-1:0] r_tcnt;
  logic [BW-1:0] r_bcnt;
  logic          r_blink;
  logic          r_hour;
  logic          r_min;
  logic          r_clr;

  state_t w_nstate;
  logic   w_mpress;
  logic   w_hour;
  logic   w_min;
  logic   w_clr;
  logic   w_set;
  logic   w_set_n;
  logic   w_enter;
  logic   w_tmo;
  logic   w_inc_arm;
  logic   w_m_rise, w_m_fall, w_m_long, w_m_rpt;
  logic   w_i_rise, w_i_fall, w_i_long, w_i_rpt;
  logic   w_unused;

  key_hold_rpt #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_key_mode (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_mode),
    .repeat_en (1'b0),
    .arm       (1'b1),
    .rise_p    (w_m_rise),
    .fall_p    (w_m_fall),
    .long_p    (w_m_long),
    .rpt_p     (w_m_rpt)
  );

  key_hold_rpt #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_key_inc (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_inc),
    .repeat_en (w_set),
    .arm       (w_inc_arm),
    .rise_p    (w_i_rise),
    .fall_p    (w_i_fall),
    .long_p    (w_i_long),
    .rpt_p     (w_i_rpt)
  );

  assign w_unused  = ^{w_m_rpt, w_i_fall, w_i_long};
  assign w_set     = (r_state != ST_RUN);
  assign w_set_n   = (w_nstate != ST_RUN);
  assign w_enter   = w_set_n && (w_nstate != r_state);
  assign w_tmo     = (r_tcnt == TW'(TIMEOUT_CYC));
  assign w_inc_arm = (w_nstate == r_state);

  // r_mpress marks a mode press that began in RUN.
  always_comb begin
    w_nstate = r_state;
    w_mpress = r_mpress;
    w_hour   = 1'b0;
    w_min    = 1'b0;
    w_clr    = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_m_rise) begin
          w_mpress = 1'b1;
        end else if (r_mpress && w_m_long) begin
          w_clr    = 1'b1;
          w_mpress = 1'b0;
        end else if (r_mpress && w_m_fall) begin
          w_nstate = ST_SET_HOUR;
          w_mpress = 1'b0;
        end
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        w_mpress = 1'b0;
        if (w_m_rise) begin
          w_nstate = (r_state == ST_SET_HOUR)
                   ? ST_SET_MIN : ST_RUN;
        end else if (w_i_rise || w_i_rpt) begin
          w_hour = (r_state == ST_SET_HOUR);
          w_min  = (r_state == ST_SET_MIN);
        end else if (w_tmo) begin
          w_nstate = ST_RUN;
        end
      end
      default: begin
        w_nstate = ST_RUN;
        w_mpress = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_mpress <= 1'b0;
      r_hour   <= 1'b0;
      r_min    <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_mpress <= w_mpress;
      r_hour   <= w_hour;
      r_min    <= w_min;
      r_clr    <= w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
    end else if (!w_set_n) begin
      r_tcnt <= '0;
    end else if (w_enter || w_m_rise || w_i_rise || w_i_rpt) begin
      r_tcnt <= TW'(1);
    end else if (r_tcnt != TW'(TIMEOUT_CYC)) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (!w_set_n) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (w_enter) begin
      r_bcnt  <= BW'(1);
      r_blink <= 1'b1;
    end else if (r_bcnt == BW'(BLINK_HALF)) begin
      r_bcnt  <= BW'(1);
      r_blink <= ~r_blink;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  assign mode         = r_state;
  assign adj_hour_p   = r_hour;
  assign adj_min_p    = r_min;
  assign clear_time_p = r_clr;
  assign blink        = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timing constants.
// Inputs driven and outputs sampled 1 ns after each rising edge.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       adj_hour_p;
  logic       adj_min_p;
  logic       clear_time_p;
  logic [1:0] mode;
  logic       blink;

  int n_cmp = 0;
  int n_bad = 0;

  time_set_ctrl #(
    .HOLD_CYC    (10),
    .REPEAT_CYC  (4),
    .TIMEOUT_CYC (50),
    .BLINK_HALF  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .adj_hour_p   (adj_hour_p),
    .adj_min_p    (adj_min_p),
    .clear_time_p (clear_time_p),
    .mode         (mode),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nstb();
    return int'(adj_hour_p) + int'(adj_min_p)
         + int'(clear_time_p);
  endfunction

  function automatic logic [31:0] outs();
    return 32'({mode, adj_hour_p, adj_min_p,
                clear_time_p, blink});
  endfunction

  initial begin
    logic [31:0] rec;
    logic [1:0]  mor;
    int          cnt;

    #2 rst = 1'b0;
    step();
    step();
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b1;
    step();
    step();
    step();
    chk("idle_run", outs(), 32'd0);

    // short mode press -> SET_HOUR on release, blink
    btn_mode = 1'b1;
    step();
    step();
    step();
    btn_mode = 1'b0;
    step();
    chk("mode_short_rel", 32'(mode), 32'd1);
    rec = '0;
    rec[0] = blink;
    for (int j = 1; j <= 10; j++) begin
      step();
      rec[j] = blink;
    end
    chk("blink_wave", rec, 32'h41F);
    btn_inc = 1'b1;
    step();
    chk("inc_first_hour", 32'({adj_hour_p, adj_min_p}),
        32'd2);
    cnt = 0;
    step();
    cnt += nstb();
    btn_inc = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step();
      cnt += nstb();
    end
    chk("inc_no_extra", 32'(cnt), 32'd0);
    chk("mode_still_hour", 32'(mode), 32'd1);

    // SET_MIN auto-repeat
    btn_mode = 1'b1;
    step();
    chk("mode_to_min", 32'(mode), 32'd2);
    btn_mode = 1'b0;
    step();
    btn_inc = 1'b1;
    rec = '0;
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      rec[j] = adj_min_p;
      cnt += int'(adj_hour_p) + int'(clear_time_p);
      if (j == 24) btn_inc = 1'b0;
    end
    chk("rpt_min_pattern", rec, 32'h0044_4401);
    chk("rpt_no_other", 32'(cnt), 32'd0);
    chk("mode_min_kept", 32'(mode), 32'd2);

    // back to RUN, then long press clear
    btn_mode = 1'b1;
    step();
    chk("min_to_run", outs(), 32'd0);
    btn_mode = 1'b0;
    step();
    chk("release_ignored", 32'(mode), 32'd0);
    btn_mode = 1'b1;
    rec = '0;
    mor = '0;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      rec[j] = clear_time_p;
      mor |= mode;
      cnt += int'(adj_hour_p) + int'(adj_min_p);
      if (j == 14) btn_mode = 1'b0;
    end
    chk("clear_pattern", rec, 32'h400);
    chk("clear_mode_run", 32'(mor), 32'd0);
    chk("clear_no_adj", 32'(cnt), 32'd0);

    // mode and inc rise together in SET_HOUR
    btn_mode = 1'b1;
    step();
    step();
    btn_mode = 1'b0;
    step();
    chk("enter_hour", 32'(mode), 32'd1);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    chk("mode_wins",
        32'({mode, adj_hour_p, adj_min_p}), 32'd8);
    btn_mode = 1'b0;
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      cnt += nstb();
    end
    chk("inc_held_silent", 32'(cnt), 32'd0);
    btn_inc = 1'b0;
    step();
    btn_inc = 1'b1;
    step();
    chk("inc_repress", 32'({adj_hour_p, adj_min_p}),
        32'd1);
    btn_inc = 1'b0;
    step();

    // inactivity timeout from SET_HOUR
    btn_mode = 1'b1;
    step();
    chk("min_to_run2", 32'(mode), 32'd0);
    btn_mode = 1'b0;
    step();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    chk("enter_hour2", 32'({mode, blink}), 32'd3);
    cnt = 0;
    for (int j = 1; j <= 50; j++) begin
      step();
      cnt += nstb();
      if (j == 49) chk("pre_timeout", 32'(mode), 32'd1);
    end
    chk("timeout_run", 32'({mode, blink}), 32'd0);
    chk("timeout_silent", 32'(cnt), 32'd0);

    // async reset mid-repeat, inc held through it
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    chk("enter_hour3", 32'(mode), 32'd1);
    btn_inc = 1'b1;
    cnt = 0;
    for (int j = 0; j <= 10; j++) begin
      step();
      cnt += int'(adj_hour_p);
    end
    chk("pre_reset_rpt", 32'(cnt), 32'd2);
    chk("rpt_live", 32'(adj_hour_p), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset", outs(), 32'd0);
    step();
    step();
    rst = 1'b1;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      cnt += nstb();
    end
    chk("post_reset_quiet", 32'(cnt), 32'd0);
    chk("post_reset_mode", 32'(mode), 32'd0);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    chk("enter_hour4", 32'(mode), 32'd1);
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      cnt += nstb();
    end
    chk("held_thru_reset", 32'(cnt), 32'd0);
    btn_inc = 1'b0;
    step();
    btn_inc = 1'b1;
    step();
    chk("after_reset_repress", 32'(adj_hour_p), 32'd1);
    btn_inc = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
